// File: rtl/hazard_stall_ctrl_if.sv
// Pipeline-side signal bundle for the hazard/stall controller.
// master = pipeline (drives hazard inputs), slave = controller.
interface hazard_stall_ctrl_if #(
    parameter int REG_W  = 5,
    parameter int PERF_W = 16
);
    // ID stage operands and branch info
    logic [REG_W-1:0]  ifid_rs;
    logic [REG_W-1:0]  ifid_rt;
    logic              ifid_uses_rs;
    logic              ifid_uses_rt;
    logic              ifid_branch;
    logic              branch_taken;
    // EX and MEM stage producers
    logic [REG_W-1:0]  idex_rt;
    logic              idex_mem_read;
    logic [REG_W-1:0]  idex_dst;
    logic              idex_reg_write;
    logic [REG_W-1:0]  exmem_dst;
    logic              exmem_mem_read;
    // shared memory handshake
    logic              mem_req;
    logic              mem_ready;
    // pipeline controls
    logic              pc_write;
    logic              ifid_write;
    logic              idex_bubble;
    logic              ifid_flush;
    logic              pipe_hold;
    logic              mem_timeout;
    logic [PERF_W-1:0] stall_cycles;

    modport master (
        output ifid_rs, ifid_rt, ifid_uses_rs, ifid_uses_rt, ifid_branch, branch_taken,
               idex_rt, idex_mem_read, idex_dst, idex_reg_write, exmem_dst, exmem_mem_read,
               mem_req, mem_ready,
        input  pc_write, ifid_write, idex_bubble, ifid_flush, pipe_hold, mem_timeout,
               stall_cycles
    );

    modport slave (
        input  ifid_rs, ifid_rt, ifid_uses_rs, ifid_uses_rt, ifid_branch, branch_taken,
               idex_rt, idex_mem_read, idex_dst, idex_reg_write, exmem_dst, exmem_mem_read,
               mem_req, mem_ready,
        output pc_write, ifid_write, idex_bubble, ifid_flush, pipe_hold, mem_timeout,
               stall_cycles
    );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Hazard and stall controller for the 5-stage pipeline: load-use bubbles,
// branch-in-ID operand hazards, shared-memory freeze with timeout, IF/ID
// flush on taken branch, and a saturating stall-cycle counter.
module hazard_stall_ctrl #(
    parameter int REG_W        = 5,
    parameter int LOAD_BUBBLES = 1,
    parameter int BRANCH_IN_ID = 1,
    parameter int MEM_TIMEOUT  = 255,
    parameter int PERF_W       = 16
) (
    input  logic               clk,
    input  logic               reset,
    hazard_stall_ctrl_if.slave bus
);
    // One extra code point so the incremented wait count never wraps.
    localparam int                TCNT_W    = $clog2(MEM_TIMEOUT + 2);
    localparam logic [TCNT_W-1:0] TMO_LIMIT = TCNT_W'(MEM_TIMEOUT);
    localparam logic [1:0]        LCNT_INIT = 2'(LOAD_BUBBLES - 1);
    localparam bit                MULTI_LU  = (LOAD_BUBBLES > 1);
    localparam bit                BR_EN     = (BRANCH_IN_ID != 0);

    typedef enum logic [1:0] {RUN, LOAD, MEM_WAIT} state_t;

    state_t            state_q, state_d;
    logic [1:0]        lcnt_q, lcnt_d;
    logic [TCNT_W-1:0] tcnt_q, tcnt_d;
    logic [TCNT_W-1:0] tcnt_inc;
    logic [PERF_W-1:0] stall_q, stall_d;

    logic lu, br, memw;
    logic pc_w, ifid_w, bubble, hold, tmo;

    // Register 0 is hardwired zero, so it never carries a dependency.
    function automatic logic src_match(input logic [REG_W-1:0] r,
                                       input logic [REG_W-1:0] rs,
                                       input logic [REG_W-1:0] rt,
                                       input logic urs, input logic urt);
        return (r != '0) && ((urs && (r == rs)) || (urt && (r == rt)));
    endfunction

    // Hazard terms from the current pipeline contents.
    always_comb begin
        lu   = bus.idex_mem_read &&
               src_match(bus.idex_rt, bus.ifid_rs, bus.ifid_rt,
                         bus.ifid_uses_rs, bus.ifid_uses_rt);
        br   = BR_EN && bus.ifid_branch &&
               ((bus.idex_reg_write &&
                 src_match(bus.idex_dst, bus.ifid_rs, bus.ifid_rt,
                           bus.ifid_uses_rs, bus.ifid_uses_rt)) ||
                (bus.exmem_mem_read &&
                 src_match(bus.exmem_dst, bus.ifid_rs, bus.ifid_rt,
                           bus.ifid_uses_rs, bus.ifid_uses_rt)));
        memw = bus.mem_req && !bus.mem_ready;
    end

    assign tcnt_inc = tcnt_q + 1'b1;

    // Next state and combinational pipeline controls; reset overrides last.
    always_comb begin
        state_d = state_q;
        lcnt_d  = lcnt_q;
        tcnt_d  = tcnt_q;
        pc_w    = 1'b1;
        ifid_w  = 1'b1;
        bubble  = 1'b0;
        hold    = 1'b0;
        tmo     = 1'b0;
        case (state_q)
            RUN: begin
                if (memw) begin
                    hold    = 1'b1;
                    pc_w    = 1'b0;
                    ifid_w  = 1'b0;
                    tcnt_d  = TCNT_W'(1);
                    state_d = MEM_WAIT;
                end else if (lu || br) begin
                    pc_w   = 1'b0;
                    ifid_w = 1'b0;
                    bubble = 1'b1;
                    if (lu && MULTI_LU) begin
                        lcnt_d  = LCNT_INIT;
                        state_d = LOAD;
                    end
                end
            end
            LOAD: begin
                pc_w   = 1'b0;
                ifid_w = 1'b0;
                if (memw) begin
                    // Freeze has priority; the countdown waits with it.
                    hold = 1'b1;
                end else begin
                    bubble = 1'b1;
                    lcnt_d = lcnt_q - 2'd1;
                    if (lcnt_q <= 2'd1) state_d = RUN;
                end
            end
            MEM_WAIT: begin
                // The detection cycle in RUN is wait cycle 1, so the abort
                // lands on the wait cycle numbered MEM_TIMEOUT.
                if (memw && (tcnt_inc < TMO_LIMIT)) begin
                    hold   = 1'b1;
                    pc_w   = 1'b0;
                    ifid_w = 1'b0;
                    tcnt_d = tcnt_inc;
                end else begin
                    // Ready or aborted: release hold and behave as RUN.
                    tmo     = memw;
                    tcnt_d  = '0;
                    state_d = RUN;
                    if (lu || br) begin
                        pc_w   = 1'b0;
                        ifid_w = 1'b0;
                        bubble = 1'b1;
                        if (lu && MULTI_LU) begin
                            lcnt_d  = LCNT_INIT;
                            state_d = LOAD;
                        end
                    end
                end
            end
            default: state_d = RUN;
        endcase
        if (reset) begin
            pc_w   = 1'b0;
            ifid_w = 1'b0;
            bubble = 1'b1;
            hold   = 1'b0;
            tmo    = 1'b0;
        end
    end

    // Saturating count of cycles with the PC held.
    always_comb begin
        stall_d = stall_q;
        if (!pc_w && !(&stall_q)) stall_d = stall_q + 1'b1;
    end

    // State and counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
            lcnt_q  <= '0;
            tcnt_q  <= '0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            lcnt_q  <= lcnt_d;
            tcnt_q  <= tcnt_d;
            stall_q <= stall_d;
        end
    end

    assign bus.pc_write     = pc_w;
    assign bus.ifid_write   = ifid_w;
    assign bus.idex_bubble  = bubble;
    assign bus.ifid_flush   = bus.branch_taken && pc_w;
    assign bus.pipe_hold    = hold;
    assign bus.mem_timeout  = tmo;
    assign bus.stall_cycles = stall_q;
endmodule
